// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data-memory responder.
// Holds the responder FSM state type, word geometry, the wait-state
// ceiling, and the byte-lane merge used when a store commits.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_BYTES_PER_WORD = 4;
  localparam int DMEM_MAX_WAIT       = 15;

  // Replace the byte lanes of old_word selected by be with the matching
  // lanes of new_word; unselected lanes keep their old contents.
  function automatic logic [31:0] dmem_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < DMEM_BYTES_PER_WORD; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage behind the responder.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low clear of every word
//   we     - write strobe for the word at idx
//   idx    - word index (shared by read and write)
//   be     - byte-lane enables for the write
//   wdata  - store data
//   rdata  - current contents of the word at idx (combinational read)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ENTRY_COUNT = 32,
  localparam int IDX_W      = $clog2(ENTRY_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [ENTRY_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DMEM_BYTES_PER_WORD; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface: a handshaked RAM
// that takes one load or store at a time, inserts WAIT_CYCLES wait states,
// then returns a one-cycle response. stall tells the core to hold
// pipeline_advance low while a request is pending.
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-low reset
//   req_valid   - request present, held until resp_valid
//   req_wr_en   - 1 = store, 0 = load
//   req_addr    - byte address
//   req_wdata   - store data
//   req_be      - store byte enables (lane i = bits 8i+7:8i)
//   req_ready   - request is accepted on an edge where this and req_valid are high
//   resp_valid  - one-cycle response strobe
//   resp_rdata  - load data, or the merged word for a store
//   addr_err    - with resp_valid: address misaligned or out of range
//   stall       - pipeline hold request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr_en,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        stall
);

  localparam int          IDX_W     = $clog2(ENTRY_COUNT);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  if (BIT_WIDTH != 32) begin : g_bad_width
    $error("dmem_responder: BIT_WIDTH must be 32");
  end
  if (ENTRY_COUNT < 2 || (ENTRY_COUNT & (ENTRY_COUNT - 1)) != 0) begin : g_bad_entries
    $error("dmem_responder: ENTRY_COUNT must be a power of 2 and at least 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  dmem_state_e state_q, state_d;
  logic [3:0]  wait_cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        wr_en_q, err_q;

  logic             accept, enter_resp;
  logic [31:0]      op_addr, op_wdata, array_rdata, resp_word;
  logic [3:0]       op_be;
  logic             op_wr_en, op_err, array_we;
  logic [IDX_W-1:0] op_idx;

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait states the commit lands on the accept edge itself, before
  // the latches are loaded, so the live request is used while still in IDLE.
  assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign op_be    = (state_q == IDLE) ? req_be    : be_q;
  assign op_wr_en = (state_q == IDLE) ? req_wr_en : wr_en_q;

  assign op_idx = op_addr[2 +: IDX_W];
  // Any set bit above the index field means addr >= 4*ENTRY_COUNT.
  assign op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:IDX_W+2] != '0);

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign array_we   = enter_resp && op_wr_en && !op_err;
  assign resp_word  = op_wr_en ? dmem_merge(array_rdata, op_wdata, op_be) : array_rdata;

  dmem_array #(
    .ENTRY_COUNT(ENTRY_COUNT)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (array_we),
    .idx  (op_idx),
    .be   (op_be),
    .wdata(op_wdata),
    .rdata(array_rdata)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (wait_cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_en_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        be_q       <= req_be;
        wr_en_q    <= req_wr_en;
        wait_cnt_q <= WAIT_LOAD;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rdata_q <= op_err ? '0 : resp_word;
        err_q   <= op_err;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign addr_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random loads/stores, checked against a word-array model.
module tb_dmem_responder;

  localparam int WAIT_A  = 2;
  localparam int WAIT_B  = 0;
  localparam int ENTRIES = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [2];
  logic        req_wr_en  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        addr_err   [2];
  logic        stall      [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        expq0[$];
  exp_t        expq1[$];
  logic [31:0] model_mem [2][ENTRIES];
  bit          held [2];

  always #5 clk = ~clk;

  dmem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(ENTRIES), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_wr_en(req_wr_en[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .addr_err(addr_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(ENTRIES), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_wr_en(req_wr_en[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .addr_err(addr_err[1]),
    .stall(stall[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: memory is a plain array of words; a store overwrites the
  // enabled bytes, and every response reports the word as it then stands.
  task automatic modelAccess(input int d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
    int w;
    e.err = ((addr % 4) != 0) || (addr >= 32'(4 * ENTRIES));
    if (e.err) begin
      e.rdata = 32'h0;
    end else begin
      w = int'(addr / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[d][w][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      e.rdata = model_mem[d][w];
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < ENTRIES; i++) model_mem[d][i] = 32'h0;
  endtask

  task automatic monitorDut(input int d);
    exp_t e;
    int   depth;
    depth = (d == 0) ? expq0.size() : expq1.size();
    if (resp_valid[d] === 1'b1) begin
      if (depth == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL dut%0d unexpected response: actual=resp_valid 1 required=no response pending at %0t", d, $time);
      end else begin
        if (d == 0) e = expq0.pop_front();
        else        e = expq1.pop_front();
        checkOutput($sformatf("dut%0d resp_rdata", d), resp_rdata[d], e.rdata);
        checkOutput($sformatf("dut%0d addr_err", d), 32'(addr_err[d]), 32'(e.err));
      end
    end else begin
      checkOutput($sformatf("dut%0d idle resp_rdata", d), resp_rdata[d], 32'h0);
      checkOutput($sformatf("dut%0d idle addr_err", d), 32'(addr_err[d]), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    monitorDut(0);
    monitorDut(1);
  end

  // Presents one request and walks it cycle by cycle to its response. If the
  // previous request was left asserted (hold_after), this one is driven during
  // that RESP cycle and must not be taken until the following IDLE cycle.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input bit hold_after);
    exp_t e;
    int   w;
    w = (d == 0) ? WAIT_A : WAIT_B;
    if (held[d]) begin
      req_valid[d] = 1'b1; req_wr_en[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
      #1;
      checkOutput($sformatf("dut%0d req_ready during RESP", d), 32'(req_ready[d]), 32'h0);
      checkOutput($sformatf("dut%0d stall during RESP", d), 32'(stall[d]), 32'h0);
      @(negedge clk);
    end else begin
      @(negedge clk);
      req_valid[d] = 1'b1; req_wr_en[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    end
    #1;
    checkOutput($sformatf("dut%0d req_ready in IDLE", d), 32'(req_ready[d]), 32'h1);
    checkOutput($sformatf("dut%0d stall on request", d), 32'(stall[d]), 32'h1);
    checkOutput($sformatf("dut%0d resp_valid on request", d), 32'(resp_valid[d]), 32'h0);
    modelAccess(d, wr, addr, wdata, be, e);
    if (d == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    for (int j = 1; j <= w + 1; j++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("dut%0d resp_valid timing", d), 32'(resp_valid[d]), 32'(j == w + 1));
      checkOutput($sformatf("dut%0d stall timing", d), 32'(stall[d]), 32'(j != w + 1));
      checkOutput($sformatf("dut%0d req_ready busy", d), 32'(req_ready[d]), 32'h0);
    end
    if (!hold_after) req_valid[d] = 1'b0;
    held[d] = hold_after;
  endtask

  task automatic randomOp(input int d, input bit hold_after);
    logic [31:0] addr;
    int          kind;
    kind = $urandom_range(0, 9);
    addr = 32'($urandom_range(0, ENTRIES - 1)) * 32'd4;
    if (kind == 8)      addr = addr + 32'($urandom_range(1, 3));
    else if (kind == 9) addr = ($urandom() | 32'h80) & 32'hFFFF_FFFC;
    applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)), hold_after);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit h;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wr_en[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; held[d] = 1'b0;
    end
    clearModel();

    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'h1);
      checkOutput($sformatf("dut%0d reset resp_valid", d), 32'(resp_valid[d]), 32'h0);
      checkOutput($sformatf("dut%0d reset resp_rdata", d), resp_rdata[d], 32'h0);
      checkOutput($sformatf("dut%0d reset addr_err", d), 32'(addr_err[d]), 32'h0);
      checkOutput($sformatf("dut%0d reset stall", d), 32'(stall[d]), 32'h0);
    end
    rst = 1'b1;

    $display("[TB] directed sequence, 2 wait states");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(0, 1'b1, 32'h10, 32'h11223344, 4'h3, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, 4'hF, 1'b0);
    applyStimulus(0, 1'b1, 32'h80, 32'hCAFEBABE, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);

    $display("[TB] directed sequence, 0 wait states");
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h08, 32'h12345678, 4'hC, 1'b0);
    applyStimulus(1, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0);

    $display("[TB] reset during wait states");
    @(negedge clk);
    req_valid[0] = 1'b1; req_wr_en[0] = 1'b1; req_addr[0] = 32'h04;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
    @(negedge clk);
    #1;
    checkOutput("abort stall in WAIT", 32'(stall[0]), 32'h1);
    rst = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    checkOutput("abort req_ready under reset", 32'(req_ready[0]), 32'h1);
    checkOutput("abort stall under reset", 32'(stall[0]), 32'h0);
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("abort resp_valid under reset", 32'(resp_valid[0]), 32'h0);
    end
    clearModel();
    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      h = (i != 39) && ($urandom_range(0, 3) == 0);
      randomOp(0, h);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 25; i++) begin
      h = (i != 24) && ($urandom_range(0, 3) == 0);
      randomOp(1, h);
      if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("dut0 responses outstanding", 32'(expq0.size()), 32'h0);
    checkOutput("dut1 responses outstanding", 32'(expq1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
